// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM states, instruction size and reset default.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } pc_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_beqadder.sv
// Plain two-operand adder shared with the BEQ target path; reused here as the PC incrementer.
module BEQAdder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] ValueIn1,
  input  logic [WIDTH-1:0] ValueIn2,
  output logic [WIDTH-1:0] ValueOut
);

  assign ValueOut = ValueIn1 + ValueIn2;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential +4 fetch, BEQ redirects with a one-entry stall buffer,
// and a fixed-length flush window after every redirect.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        BranchValid,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] PCOut,
  output logic [31:0] PCPlus4,
  output logic        FetchValid,
  output logic        Flush,
  output logic        BranchAck,
  output logic        AlignErr
);

  pc_state_t   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [2:0]  r_flush_cnt, w_flush_cnt_nxt;
  logic        r_pend_valid, w_pend_valid_nxt;
  logic [31:0] r_pend_target, w_pend_target_nxt;
  logic        r_ack, w_ack_nxt;
  logic        r_align_err, w_align_err_nxt;

  logic [31:0] w_pc_plus4;
  logic        w_accept;
  logic        w_take_now;
  logic        w_pend_cap;
  logic        w_pend_apply;
  logic        w_redirect;
  logic [31:0] w_target;

  BEQAdder #(.WIDTH(32)) u_pc_inc (
    .ValueIn1 (r_pc),
    .ValueIn2 (32'(INSTR_BYTES)),
    .ValueOut (w_pc_plus4)
  );

  // Only RUN accepts branches; a full pending slot blocks any newer one so the older wins.
  assign w_accept     = (r_state == ST_RUN) && BranchValid && !r_pend_valid;
  assign w_take_now   = w_accept && BranchTaken && !Stall;
  assign w_pend_cap   = w_accept && BranchTaken && Stall;
  assign w_pend_apply = (r_state == ST_RUN) && r_pend_valid && !Stall;
  assign w_redirect   = w_take_now || w_pend_apply;
  assign w_target     = r_pend_valid ? r_pend_target : BranchTarget;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_flush_cnt   <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_ack         <= 1'b0;
      r_align_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_target <= w_pend_target_nxt;
      r_ack         <= w_ack_nxt;
      r_align_err   <= w_align_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_flush_cnt_nxt   = r_flush_cnt;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_target_nxt = r_pend_target;
    w_ack_nxt         = w_accept;
    w_align_err_nxt   = r_align_err;

    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_redirect) begin
          w_pc_nxt         = {w_target[31:2], 2'b00};
          w_state_nxt      = ST_FLUSH;
          w_flush_cnt_nxt  = 3'(FLUSH_CYCLES);
          w_pend_valid_nxt = 1'b0;
          if (w_target[1:0] != 2'b00) w_align_err_nxt = 1'b1;
        end else begin
          if (!Stall) w_pc_nxt = w_pc_plus4;
          if (w_pend_cap) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_target_nxt = BranchTarget;
          end
        end
      end
      ST_FLUSH: begin
        // The flush window is time-based, so it drains even while the PC is held.
        if (!Stall) w_pc_nxt = w_pc_plus4;
        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
        if (r_flush_cnt <= 3'd1) begin
          w_flush_cnt_nxt = '0;
          w_state_nxt     = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign PCOut      = r_pc;
  assign PCPlus4    = w_pc_plus4;
  assign FetchValid = (r_state != ST_IDLE);
  assign Flush      = (r_state == ST_FLUSH);
  assign BranchAck  = r_ack;
  assign AlignErr   = r_align_err;

endmodule
